dot_accum: RTL and testbench
============================

// Module: dot_accum
// PURPOSE
//  Downstream consumer of the 8-bit 4-operand multiply-add stage (E = A*B + C*D, 17 bits).
//  Accumulates a programmable number of E results into one wider sum (dot-product reduction),
//  saturating on overflow. Presents the total on a valid/ready output port.
//  Input side uses in_valid/in_ready, so upstream bubbles are tolerated.
// PARAMETERS
//  IN_W   17  width of in_data (upstream E width)
//  ACC_W  24  accumulator / out_data width (ACC_W >= IN_W)
//  CNT_W  4   width of len; max beats per run = 2**CNT_W-1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  start      in   1      begin a run; sampled only in IDLE
//  len        in   CNT_W  beats to accumulate; captured with start
//  in_valid   in   1      in_data holds a valid upstream result
//  in_data    in   IN_W   unsigned result from the multiply-add stage
//  in_ready   out  1      block accepts a beat this cycle
//  out_valid  out  1      out_data holds the final sum
//  out_data   out  ACC_W  accumulated sum, unsigned, saturated
//  out_ready  in   1      consumer takes out_data
//  ovf        out  1      sticky: saturation occurred in the current/last run
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, acc=0, cnt=0, len_q=0.
//   Outputs next cycle: out_valid=0, out_data=0, ovf=0, in_ready=0, busy=0.
//   rst overrides all other inputs, including mid-run: run aborted, no output produced.
//  FSM states: IDLE, ACC, DONE.
//   in_ready = (state==ACC), combinational. busy = (state!=IDLE).
//  IDLE:
//   start=1, len!=0 -> ACC; len_q<=len, acc<=0, cnt<=0, ovf<=0.
//   start=1, len==0 -> DONE; out_data<=0, ovf<=0.
//   start=0 -> stay; out_data/ovf keep last run's values.
//  ACC:
//   Beat = in_valid & in_ready. Cycles with in_valid=0 change nothing.
//   On beat: sum = acc + in_data, computed ACC_W+1 wide.
//    If sum > 2**ACC_W-1: acc <= 2**ACC_W-1 and ovf <= 1.
//    Otherwise acc <= sum.
//    cnt <= cnt+1.
//   On the beat with cnt==len_q-1: out_data <= saturated sum, state <= DONE.
//   start is ignored while in ACC.
//  DONE:
//   out_valid=1; out_data and ovf held stable; in_ready=0.
//   out_valid rises the cycle after the last accepted beat (latency 1).
//   out_ready=1 -> IDLE next cycle, out_valid=0 next cycle.
//   A same-cycle start is ignored; it is re-sampled once back in IDLE.
//  Saturated acc stays clamped for later beats (stays at max); ovf stays 1 until the next start.
//  Upstream max E = 2*255*255 = 130050.
//   Default ACC_W=24 therefore never saturates for len <= 15.
// TESTING
//  1 rst; start len=4; beats 200,300,400,500 back-to-back
//    -> out_valid one cycle after 4th beat; out_data=1400, ovf=0.
//  2 len=3, beats 10,20,30 with 2-cycle in_valid gaps between beats
//    -> only valid beats counted; out_data=60.
//  3 ACC_W=18; len=3, beats 130050 x3
//    -> out_data=262143, ovf=1. Next run len=1, beat 5 -> out_data=5, ovf=0.
//  4 In DONE, out_ready=0 for 5 cycles, in_valid=1, start=1
//    -> out_data stable, in_ready=0, no new run. out_ready=1 -> IDLE, out_valid=0 next cycle.
//  5 rst=1 after 2 of 4 beats -> next cycle all outputs 0, no out_valid.
//    Fresh start len=1, beat 7 -> out_data=7.
//  6 start len=0 -> DONE next cycle, out_data=0.
//    start pulsed during ACC -> ignored; len_q unchanged.

Source files
------------

// File: rtl/dot_accum.sv
// Dot-product reduction stage: sums a programmable number of unsigned upstream
// results into a wider saturating accumulator and hands the total out on valid/ready.
module dot_accum #(
  parameter int IN_W  = 17,
  parameter int ACC_W = 24,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready depends only on state; out_valid is held until out_ready.
  state_t             r_state;
  state_t             w_next_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_len_q;
  logic [ACC_W-1:0]   r_out_data;
  logic               r_ovf;

  logic               w_beat;
  logic               w_last;
  logic [ACC_W:0]     w_in_ext;
  logic [ACC_W:0]     w_sum;
  logic               w_sum_ovf;
  logic [ACC_W-1:0]   w_sat;

  // One extra bit is enough: acc never exceeds max, so acc + in_data < 2**(ACC_W+1).
  assign w_in_ext  = {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
  assign w_sum     = {1'b0, r_acc} + w_in_ext;
  assign w_sum_ovf = w_sum[ACC_W];
  assign w_sat     = w_sum_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_beat    = in_valid && (r_state == S_ACC);
  assign w_last    = (r_cnt == (r_len_q - CNT_W'(1)));

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = (len != '0) ? S_ACC : S_DONE;
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (w_beat && w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len_q    <= '0;
      r_out_data <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ovf <= 1'b0;
            if (len != '0) begin
              r_len_q <= len;
              r_acc   <= '0;
              r_cnt   <= '0;
            end else begin
              r_out_data <= '0;
            end
          end
        end
        S_ACC: begin
          if (w_beat) begin
            r_acc <= w_sat;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_sum_ovf) begin
              r_ovf <= 1'b1;
            end
            if (w_last) begin
              r_out_data <= w_sat;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data    = r_out_data;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dot_accum.sv
// Bench for dot_accum: two instances (default width and an 18-bit accumulator that
// can saturate) share one stimulus stream; each has its own expected queue.
module tb_dot_accum;

  localparam int IN_W  = 17;
  localparam int CNT_W = 4;
  localparam int AW_A  = 24;
  localparam int AW_B  = 18;
  localparam longint MAX_A = (64'd1 << AW_A) - 1;
  localparam longint MAX_B = (64'd1 << AW_B) - 1;
  localparam int E_MAX = 130050;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_ready = 1'b0;

  logic             in_ready_a, out_valid_a, ovf_a, busy_a;
  logic [AW_A-1:0]  out_data_a;
  logic [1:0]       dbg_a;
  logic             in_ready_b, out_valid_b, ovf_b, busy_b;
  logic [AW_B-1:0]  out_data_b;
  logic [1:0]       dbg_b;

  dot_accum #(.IN_W(IN_W), .ACC_W(AW_A), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready_a), .out_valid(out_valid_a),
    .out_data(out_data_a), .out_ready(out_ready), .ovf(ovf_a), .busy(busy_a),
    .o_dbg_state(dbg_a)
  );

  dot_accum #(.IN_W(IN_W), .ACC_W(AW_B), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready_b), .out_valid(out_valid_b),
    .out_data(out_data_b), .out_ready(out_ready), .ovf(ovf_b), .busy(busy_b),
    .o_dbg_state(dbg_b)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [AW_A:0] exp_a_q[$];
  logic [AW_B:0] exp_b_q[$];
  int beat_q[$];

  // reference model: plain saturating sums per width
  longint acc_a, acc_b;
  bit     mo_a, mo_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_beat(input longint b);
    acc_a += b;
    if (acc_a > MAX_A) begin acc_a = MAX_A; mo_a = 1'b1; end
    acc_b += b;
    if (acc_b > MAX_B) begin acc_b = MAX_B; mo_b = 1'b1; end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid_a"}, out_valid_a, 0);
    check({tag, "_out_data_a"},  out_data_a,  0);
    check({tag, "_ovf_a"},       ovf_a,       0);
    check({tag, "_in_ready_a"},  in_ready_a,  0);
    check({tag, "_busy_a"},      busy_a,      0);
    check({tag, "_out_valid_b"}, out_valid_b, 0);
    check({tag, "_out_data_b"},  out_data_b,  0);
    check({tag, "_ovf_b"},       ovf_b,       0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    check_zero("reset");
  endtask

  // One complete run: start, L beats with random bubbles, hold in DONE, handshake.
  task automatic run(input int L, input int gmin, input int gmax, input int hold_max,
                     input bit poke);
    int b;
    int gap;
    int hold;
    logic [AW_A:0] e_a;
    logic [AW_B:0] e_b;
    check("idle_busy_a", busy_a, 0);
    start = 1'b1;
    len = CNT_W'(L);
    cyc();
    start = 1'b0;
    len = CNT_W'($urandom);
    acc_a = 0; acc_b = 0; mo_a = 1'b0; mo_b = 1'b0;
    if (L != 0) begin
      check("start_busy_a", busy_a, 1);
      check("start_ovf_cleared_b", ovf_b, 0);
    end
    for (int i = 0; i < L; i++) begin
      gap = $urandom_range(gmax, gmin);
      repeat (gap) begin
        in_valid = 1'b0;
        in_data = IN_W'($urandom);
        if (poke) begin
          start = 1'($urandom_range(0, 1));
          len = CNT_W'($urandom);
        end
        cyc();
      end
      start = 1'b0;
      if (beat_q.size() > 0) b = beat_q.pop_front();
      else b = ($urandom_range(0, 3) == 0) ? E_MAX : int'($urandom_range(0, E_MAX));
      in_valid = 1'b1;
      in_data = IN_W'(b);
      @(negedge clk);
      check("acc_in_ready_a", in_ready_a, 1);
      check("acc_in_ready_b", in_ready_b, 1);
      check("acc_out_valid_a", out_valid_a, 0);
      cyc();
      in_valid = 1'b0;
      model_beat(b);
      check("beat_ovf_a", ovf_a, mo_a);
      check("beat_ovf_b", ovf_b, mo_b);
    end
    e_a = {mo_a, AW_A'(acc_a)};
    e_b = {mo_b, AW_B'(acc_b)};
    exp_a_q.push_back(e_a);
    exp_b_q.push_back(e_b);
    // one cycle after the last beat (or after a len=0 start) the result is offered
    check("latency_out_valid_a", out_valid_a, 1);
    check("latency_out_valid_b", out_valid_b, 1);
    check("done_in_ready_a", in_ready_a, 0);
    hold = $urandom_range(0, hold_max);
    out_ready = 1'b0;
    repeat (hold) begin
      start = 1'b1;
      len = CNT_W'($urandom_range(1, 15));
      in_valid = 1'b1;
      in_data = IN_W'($urandom);
      cyc();
      check("hold_out_valid_a", out_valid_a, 1);
      check("hold_in_ready_a", in_ready_a, 0);
    end
    out_ready = 1'b1;
    start = (hold > 0);
    cyc();
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("after_out_valid_a", out_valid_a, 0);
    check("after_busy_a", busy_a, 0);
    check("after_busy_b", busy_b, 0);
    check("idle_keep_data_a", {ovf_a, out_data_a}, e_a);
    check("idle_keep_data_b", {ovf_b, out_data_b}, e_b);
    cyc();
  endtask

  // monitor: compares every cycle the DUT offers a result, pops on handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_a) begin
        if (exp_a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_a actual=%0d expected=none", out_data_a);
        end else begin
          check("out_a", {ovf_a, out_data_a}, exp_a_q[0]);
          if (out_ready) void'(exp_a_q.pop_front());
        end
      end
      if (out_valid_b) begin
        if (exp_b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_b actual=%0d expected=none", out_data_b);
        end else begin
          check("out_b", {ovf_b, out_data_b}, exp_b_q[0]);
          if (out_ready) void'(exp_b_q.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();

    // back-to-back beats
    beat_q = '{200, 300, 400, 500};
    run(4, 0, 0, 0, 1'b0);
    check("s1_sum_a", out_data_a, 1400);
    check("s1_ovf_a", ovf_a, 0);

    // bubbles between beats
    beat_q = '{10, 20, 30};
    run(3, 2, 2, 0, 1'b0);
    check("s2_sum_a", out_data_a, 60);

    // saturation in the narrow instance, then a clean run clears ovf
    beat_q = '{E_MAX, E_MAX, E_MAX};
    run(3, 0, 1, 0, 1'b0);
    check("s3_sat_b", out_data_b, MAX_B);
    check("s3_ovf_b", ovf_b, 1);
    check("s3_wide_a", out_data_a, 3 * E_MAX);
    beat_q = '{5};
    run(1, 0, 0, 0, 1'b0);
    check("s3_next_b", out_data_b, 5);
    check("s3_next_ovf_b", ovf_b, 0);

    // long stall in DONE with start / in_valid asserted
    beat_q = '{1, 2};
    run(2, 0, 0, 5, 1'b0);

    // reset mid-run: run aborted, no output
    start = 1'b1; len = CNT_W'(4);
    cyc();
    start = 1'b0;
    repeat (2) begin
      in_valid = 1'b1; in_data = IN_W'(99);
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_zero("midrun_reset");
    beat_q = '{7};
    run(1, 0, 0, 0, 1'b0);
    check("s5_sum_a", out_data_a, 7);

    // len = 0, then start pulses during ACC
    run(0, 0, 0, 1, 1'b0);
    check("s6_zero_a", out_data_a, 0);
    beat_q = '{3, 4, 5, 6, 7, 8};
    run(6, 1, 2, 1, 1'b1);
    check("s6_len_kept_a", out_data_a, 33);

    // randomized runs
    for (int r = 0; r < 30; r++) begin
      run($urandom_range(0, 15), 0, $urandom_range(0, 2), 3, 1'($urandom_range(0, 1)));
    end

    repeat (3) cyc();
    check("drain_a", exp_a_q.size(), 0);
    check("drain_b", exp_b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
